// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and
// the default RAM geometry.
package mem_copy_engine_pkg;

  localparam int RAM_WIDTH_DEF     = 16;
  localparam int RAM_ADDR_BITS_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word ascending RAM copy engine driving one single-port RAM interface.
// Optional constant-fill mode is compiled in when MEM_COPY_FILL_EN is defined.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] src_addr,
  input  logic [RAM_ADDR_BITS-1:0] dst_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_din,
`ifdef MEM_COPY_FILL_EN
  input  logic                     fill_mode,
  input  logic [RAM_WIDTH-1:0]     fill_value,
`endif
  input  logic [RAM_WIDTH-1:0]     mem_dout
);

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

  state_e                   r_state;
  logic [RAM_ADDR_BITS-1:0] r_src;
  logic [RAM_ADDR_BITS-1:0] r_dst;
  logic [RAM_ADDR_BITS:0]   r_cnt;
  logic [RAM_WIDTH-1:0]     r_data;
  logic                     r_fill;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_mem_en;
  logic                     r_mem_we;
  logic [RAM_ADDR_BITS-1:0] r_mem_addr;

  logic                     w_fill_req;
  logic [RAM_WIDTH-1:0]     w_fill_val;
  logic [RAM_ADDR_BITS-1:0] w_src_nxt;
  logic [RAM_ADDR_BITS-1:0] w_dst_nxt;
  logic                     w_last;

`ifdef MEM_COPY_FILL_EN
  assign w_fill_req = fill_mode;
  assign w_fill_val = fill_value;
`else
  assign w_fill_req = 1'b0;
  assign w_fill_val = '0;
`endif

  // Address increments wrap naturally at the address width.
  assign w_src_nxt = r_src + ADDR_ONE;
  assign w_dst_nxt = r_dst + ADDR_ONE;
  assign w_last    = (r_cnt == CNT_ONE);

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_data;

  // Outputs are registered together with the state so they always describe the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_fill     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_cnt  <= length;
            r_fill <= w_fill_req;
            r_busy <= 1'b1;
            if (length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (w_fill_req) begin
              r_state    <= ST_WRITE;
              r_data     <= w_fill_val;
              r_mem_en   <= 1'b1;
              r_mem_we   <= 1'b1;
              r_mem_addr <= dst_addr;
            end else begin
              r_state    <= ST_READ;
              r_mem_en   <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= src_addr;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_state  <= ST_CAPT;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
        ST_CAPT: begin
          // The RAM returns the word read in READ during this cycle.
          r_state    <= ST_WRITE;
          r_data     <= mem_dout;
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_dst;
        end
        ST_WRITE: begin
          r_src <= w_src_nxt;
          r_dst <= w_dst_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_state  <= ST_DONE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
          end else if (r_fill) begin
            r_state    <= ST_WRITE;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_dst_nxt;
          end else begin
            r_state    <= ST_READ;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_src_nxt;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_fill  <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_fill   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter RAM_WIDTH, default 16, data word width in bits.
REQ-002 Parameter RAM_ADDR_BITS, default 15, word address width in bits.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src_addr  input  RAM_ADDR_BITS  first source word address, latched when start is accepted.
REQ-007 dst_addr  input  RAM_ADDR_BITS  first destination word address, latched when start is accepted.
REQ-008 length  input  RAM_ADDR_BITS+1  word count, latched when start is accepted; 0 means no-op.
REQ-009 busy  output  1  high in every non-IDLE state.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 mem_en  output  1  RAM port enable.
REQ-012 mem_we  output  1  RAM port write enable.
REQ-013 mem_addr  output  RAM_ADDR_BITS  RAM port address.
REQ-014 mem_din  output  RAM_WIDTH  RAM port write data.
REQ-015 mem_dout  input  RAM_WIDTH  RAM port read data; valid the cycle after a read edge, write-first semantics.

Function
REQ-016 FSM states SHALL be IDLE, READ, CAPT, WRITE and DONE.
REQ-017 IDLE: mem_en, mem_we, busy and done SHALL be 0; start=1 with length>0 SHALL go to READ; start=1 with length=0 SHALL go to DONE.
REQ-018 READ: drive mem_en=1, mem_we=0, mem_addr=current source address; next state CAPT.
REQ-019 CAPT: drive mem_en=0; latch mem_dout into an internal data register; next state WRITE.
REQ-020 WRITE: drive mem_en=1, mem_we=1, mem_addr=current destination address, mem_din=data register; increment both addresses, decrement the remaining count; next state READ if the count is still nonzero, otherwise DONE.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-022 Address increments SHALL wrap modulo 2^RAM_ADDR_BITS (for example 0x7FFF+1 gives 0x0000).
REQ-023 Latency: done SHALL be high in the state entered 3*length edges after the start-sampling edge, or 1 edge after it when length=0.
REQ-024 start while busy=1 SHALL be ignored; it is neither queued nor allowed to alter the latched operands.
REQ-025 Copies SHALL run strictly ascending, word by word, with no overlap correction: a destination overlapping the source ahead of it replicates source words.
REQ-026 length=2^RAM_ADDR_BITS SHALL copy the entire memory exactly once.

Reset
REQ-027 While reset=1 at a rising edge: state SHALL become IDLE; busy, done, mem_en and mem_we SHALL be 0; mem_addr, mem_din, the addresses, the count and the data register SHALL be 0.
REQ-028 Reset mid-transfer SHALL abort immediately, with no further RAM accesses; words already written remain written.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro MEM_COPY_FILL_EN: when defined, the block SHALL add inputs fill_mode (1 bit) and fill_value (RAM_WIDTH bits), both latched with start.
REQ-031 With MEM_COPY_FILL_EN defined and fill_mode=1, the FSM SHALL skip READ and CAPT and write fill_value to length consecutive destination words, one per cycle; done SHALL follow length edges after the start-sampling edge.
REQ-032 With MEM_COPY_FILL_EN undefined, these ports and this logic SHALL be absent, and behaviour SHALL be exactly REQ-016 through REQ-029.

Structure
REQ-033 A shared package SHALL hold the state encodings (IDLE=0, READ=1, CAPT=2, WRITE=3, DONE=4, 3-bit) and the RAM_WIDTH/RAM_ADDR_BITS defaults.
REQ-034 The block SHALL be a single module with no sub-module; the bench SHALL connect it to port B of the dual-port RAM, with a 32768x16 memory model.

Verification
REQ-035 Preload 0x0010..0x0013 with A1,B2,C3,D4; start with src=0x0010, dst=0x0100, length=4 -> done at edge 12, 0x0100..0x0103 read A1,B2,C3,D4, busy high for 13 cycles.
REQ-036 start with length=0 -> done one edge later, mem_en never asserted, memory unchanged.
REQ-037 src=0x7FFE, dst=0x0000, length=3 -> reads of 0x7FFE, 0x7FFF, 0x0000 in order; 0x0000..0x0002 end as old[0x7FFE], old[0x7FFF], old[0x7FFE] (overlap replication).
REQ-038 Pulse start again at edge 5 of a length-4 copy -> ignored; exactly one done pulse and 4 writes in total.
REQ-039 Assert reset after the second WRITE of a length-4 copy -> next cycle is IDLE with all outputs 0; only 2 destination words modified.
REQ-040 With MEM_COPY_FILL_EN defined: fill_mode=1, fill_value=0xBEEF, dst=0x0200, length=5 -> 0x0200..0x0204 read 0xBEEF, done at edge 5, no reads issued.
